// File: rtl/minimig_io_pkg.sv
// Shared types for the minimig keyboard/mouse byte path: FIFO entry layout and output FSM states.
package minimig_io_pkg;

  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } kms_state_e;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } kms_entry_t;

endpackage

// File: rtl/kms_fifo_ram.sv
// DEPTH x ENTRY_W storage: one synchronous write port, one asynchronous read port, no reset.
module kms_fifo_ram
  import minimig_io_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  kms_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output kms_entry_t    rdata_c
);

  kms_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/kbd_mouse_fifo.sv
// Buffers user_io keyboard/mouse bytes and hands them to minimig one at a time,
// paced by GAP clk7_en pulses, using a toggle-per-byte level handshake.
module kbd_mouse_fifo
  import minimig_io_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 64
) (
  input  logic                   clk,
  input  logic                   _rst,
  input  logic                   clk7_en,
  input  logic                   flush,
  input  logic [7:0]             in_data,
  input  logic [1:0]             in_type,
  input  logic                   in_strobe,
  output logic [7:0]             out_data,
  output logic [1:0]             out_type,
  output logic                   out_level,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP + 1);

  kms_state_e    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    type_q, type_d;
  logic          level_q, level_d;
  logic          ovf_q, ovf_d;

  logic          push, pop, gap_done;
  kms_entry_t    rd_entry, wr_entry;

  assign wr_entry = '{kind: in_type, data: in_data};

  kms_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_c (rd_entry)
  );

  // Gap expires on the clk7_en pulse that brings the counter to zero.
  assign gap_done = (gap_q == '0) || (clk7_en && (gap_q == GW'(1)));

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    gap_d   = gap_q;
    data_d  = data_q;
    type_d  = type_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) state_d = ST_SEND;
        end
        ST_SEND: begin
          pop     = 1'b1;
          data_d  = rd_entry.data;
          type_d  = rd_entry.kind;
          level_d = ~level_q;
          gap_d   = GW'(GAP);
          rptr_d  = rptr_q + AW'(1);
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (gap_done) begin
            gap_d   = '0;
            state_d = (count_q != '0) ? ST_SEND : ST_IDLE;
          end else if (clk7_en) begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A same-cycle pop frees the slot, so a push at full still lands.
      push = in_strobe && ((count_q != CW'(DEPTH)) || pop);
      if (push) wptr_d = wptr_q + AW'(1);
      if (in_strobe && !push) ovf_d = 1'b1;

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      data_q  <= 8'h00;
      type_q  <= 2'b00;
      level_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      type_q  <= type_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_type  = type_q;
  assign out_level = level_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/kbd_mouse_fifo.md
KBD_MOUSE_FIFO -- requirements
Module: kbd_mouse_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries (power of two, 4..64).
REQ-002 The block SHALL have parameter GAP, default 64, meaning the number of clk7_en pulses between successive output deliveries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single 28.6875 MHz system clock (clk_28 domain).
REQ-004 The block SHALL have port _rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clk7_en, input, 1 bit: 7 MHz clock enable used for pacing.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous clear of FIFO contents.
REQ-007 The block SHALL have port in_data, input, 8 bits: keycode or mouse byte from user_io.
REQ-008 The block SHALL have port in_type, input, 2 bits: data type tag from user_io.
REQ-009 The block SHALL have port in_strobe, input, 1 bit: one-clock pulse marking in_data/in_type valid.
REQ-010 The block SHALL have port out_data, output, 8 bits: byte presented to minimig kbd_mouse_data.
REQ-011 The block SHALL have port out_type, output, 2 bits: tag presented to minimig kbd_mouse_type.
REQ-012 The block SHALL have port out_level, output, 1 bit: toggle-per-byte handshake to minimig kms_level.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.

Function
REQ-015 Push: in_strobe=1 and not full SHALL write {in_type,in_data} at the write pointer and increment count, with the entry readable on the next clk.
REQ-016 Push to a full FIFO without a same-cycle pop SHALL drop the byte, leave the contents unchanged and set overflow.
REQ-017 Push and pop in the same cycle SHALL both succeed, leaving count unchanged, including at full and at count=1.
REQ-018 Pointers SHALL wrap modulo DEPTH, and full/empty SHALL be derived from count (full when count=DEPTH, empty when count=0).
REQ-019 The output FSM SHALL have exactly three states: IDLE, SEND and WAIT.
REQ-020 IDLE: when count>0, the FSM SHALL go to SEND on the next clk.
REQ-021 SEND, one clk: the FSM SHALL pop the head entry, register it onto out_data/out_type, toggle out_level in the same cycle, load the gap counter with GAP, and go to WAIT.
REQ-022 WAIT: the gap counter SHALL decrement on each clk7_en; at zero the FSM SHALL go to SEND if count>0, otherwise to IDLE.
REQ-023 out_data/out_type SHALL hold their value until the next SEND and SHALL never change without an out_level toggle.
REQ-024 Latency from in_strobe into an empty FIFO in IDLE to the out_level toggle SHALL be 2 clk.
REQ-025 flush SHALL zero count and both pointers, and return the FSM to IDLE; out_level, out_data, out_type and overflow SHALL keep their values.
REQ-026 flush and in_strobe in the same cycle: flush SHALL win and the byte SHALL be discarded without setting overflow.
REQ-027 overflow SHALL clear only on _rst.

Reset
REQ-028 On _rst=0 the block SHALL asynchronously set count=0, both pointers=0, FSM=IDLE, gap counter=0, out_data=8'h00, out_type=2'b00, out_level=0 and overflow=0.
REQ-029 Reset asserted mid-WAIT or mid-SEND SHALL abandon the in-flight entry; no out_level toggle SHALL occur until a new push after release.
REQ-030 FIFO storage RAM SHALL NOT be reset; content validity SHALL be governed solely by count.

Structure
REQ-031 The FSM state enum and the entry width constant (10) SHALL be defined in shared package minimig_io_pkg.
REQ-032 Storage SHALL be a sub-module kms_fifo_ram: DEPTH x 10, one write port, one asynchronous read port.
REQ-033 The FSM, pointers and gap counter SHALL reside in kbd_mouse_fifo.

Verification
REQ-034 Single byte: push 8'h45/type 2'b01 into an empty FIFO -> out_level toggles 0->1 two clk later, out_data=8'h45, out_type=2'b01, count returns to 0.
REQ-035 Pacing with GAP=4: push 3 bytes back-to-back -> three toggles spaced by 4 clk7_en pulses, with bytes delivered in push order.
REQ-036 Overflow with DEPTH=16: hold the FSM in WAIT, push 17 bytes -> count=16, overflow=1, the 17th byte is never delivered, and the first 16 bytes are delivered intact.
REQ-037 Simultaneous events: push while full in the SEND cycle -> byte accepted, count stays 16, overflow stays 0.
REQ-038 Flush and reset: flush with count=5 -> count=0, no further toggles; then _rst low mid-WAIT -> all outputs take REQ-028 values immediately.
REQ-039 Wrap-around: push and drain 40 bytes with values 0..39 -> pointer wraps twice and the output sequence is exactly 0..39.
